id_branch_predict: RTL and testbench
====================================

ID_BRANCH_PREDICT -- requirements
Module: id_branch_predict

Interface
REQ-001 Parameter DATA_W, default 32, datapath/PC width (>= 32).
REQ-002 Parameter IDX_W, default 6, BHT index width (2^IDX_W entries).
REQ-003 Parameter CNT_W, default 16, mispredict counter width.
REQ-004 i_clk  in  1  single clock; all state changes on rising edge.
REQ-005 i_rst  in  1  synchronous, active-high reset.
REQ-006 i_valid  in  1  ID-stage instruction valid.
REQ-007 i_stall  in  1  pipeline hold; freezes all state.
REQ-008 i_con_instru  in  6  opcode.
REQ-009 i_con_func  in  6  function code.
REQ-010 i_con_rt  in  1  instruction bit 16 (REGIMM select).
REQ-011 i_pc  in  DATA_W  PC of ID instruction.
REQ-012 i_rs_data / i_rt_data  in  DATA_W  forwarded operands.
REQ-013 i_imm  in  16  branch offset; i_jtarget  in  26  jump index.
REQ-014 o_valid  out  1  registered result valid.
REQ-015 o_con_bop  out  3; o_con_jump  out  2  registered decode.
REQ-016 o_taken  out  1  resolved redirect; o_target  out  DATA_W  redirect address.
REQ-017 o_pred_taken  out  1  BHT prediction; o_mispredict  out  1  prediction wrong.
REQ-018 o_mp_count  out  CNT_W  saturating mispredict count.

Function
REQ-019 Decode SHALL be: 000100 beq bop=001; 000101 bne 010; 000110 blez 011; 000111 bgtz 100; 000001 with rt=0 bltz 101, rt=1 bgez 110; 000010 j and 000011 jal jump=01; 000000 with func 001000 (jr) or 001001 (jalr) jump=10; all else bop=000 jump=00.
REQ-020 Conditions SHALL use signed DATA_W compare: beq rs==rt, bne rs!=rt, blez rs<=0, bgtz rs>0, bltz rs<0, bgez rs>=0.
REQ-021 Branch target = pc+4 + (sign-extended imm << 2), modulo 2^DATA_W.
REQ-022 j/jal target = {(pc+4)[DATA_W-1:28], jtarget, 2'b00}; jr/jalr target = rs_data.
REQ-023 Jumps SHALL always set o_taken=1; non-control instructions o_taken=0, o_target=0.
REQ-024 BHT: 2^IDX_W 2-bit saturating counters indexed by i_pc[IDX_W+1:2]; prediction = counter MSB.
REQ-025 Latency: all outputs registered, valid exactly 1 cycle after accepted input (i_valid=1, i_stall=0).
REQ-026 On accepted conditional branch, same edge SHALL increment (taken) or decrement (not taken) the indexed counter, saturating at 11/00.
REQ-027 Prediction SHALL use pre-update counter value (read-before-write).
REQ-028 o_mispredict = conditional branch and o_pred_taken != o_taken; jumps and non-branches never mispredict, o_pred_taken=0 for them.
REQ-029 o_mp_count increments by 1 per mispredict, holds at all-ones.
REQ-030 i_stall=1: outputs, BHT and counter hold; no update.
REQ-031 i_valid=0, i_stall=0: o_valid=0, other outputs zeroed, no BHT update.

Reset
REQ-032 i_rst SHALL zero all outputs and o_mp_count, and set every BHT counter to 01 (weakly not-taken) within one cycle.
REQ-033 i_rst SHALL take priority over i_stall and i_valid; an in-flight instruction is discarded.

Structure
REQ-034 Shared package SHALL hold opcode/func constants, bop and jump encodings, and 2-bit counter states.
REQ-035 BHT SHALL be sub-module id_bht (read port, update port, reset init).

Verification
REQ-036 Reset, then beq pc=0x100, rs=rt=5, imm=4 -> next cycle o_taken=1, o_target=0x114, o_pred_taken=0, o_mispredict=1, o_mp_count=1.
REQ-037 Same beq repeated 3 times -> predictions 0,1,1; counter saturates at 11; o_mp_count=1.
REQ-038 jr rs=0x4000 -> o_con_jump=10, o_target=0x4000, o_taken=1, o_mispredict=0.
REQ-039 bltz rs=0x80000000 vs bgez rs=0 -> both taken, bop 101/110.
REQ-040 i_stall=1 for 3 cycles during branch stream -> outputs and o_mp_count frozen, BHT unchanged.
REQ-041 i_rst asserted mid-stream -> next cycle all outputs 0, prior trained PC predicts not-taken.

Source files
------------

// File: rtl/id_branch_predict_pkg.sv
// Shared decode constants, control encodings and BHT counter states for the
// ID-stage branch resolution / prediction block.
package id_branch_predict_pkg;

    // Primary opcodes
    localparam logic [5:0] OP_SPECIAL = 6'b000000;
    localparam logic [5:0] OP_REGIMM  = 6'b000001;
    localparam logic [5:0] OP_J       = 6'b000010;
    localparam logic [5:0] OP_JAL     = 6'b000011;
    localparam logic [5:0] OP_BEQ     = 6'b000100;
    localparam logic [5:0] OP_BNE     = 6'b000101;
    localparam logic [5:0] OP_BLEZ    = 6'b000110;
    localparam logic [5:0] OP_BGTZ    = 6'b000111;

    // SPECIAL function codes for register jumps
    localparam logic [5:0] FN_JR      = 6'b001000;
    localparam logic [5:0] FN_JALR    = 6'b001001;

    // Conditional branch operation
    typedef enum logic [2:0] {
        BOP_NONE = 3'b000,
        BOP_BEQ  = 3'b001,
        BOP_BNE  = 3'b010,
        BOP_BLEZ = 3'b011,
        BOP_BGTZ = 3'b100,
        BOP_BLTZ = 3'b101,
        BOP_BGEZ = 3'b110
    } bop_e;

    // Unconditional jump kind
    typedef enum logic [1:0] {
        JUMP_NONE = 2'b00,
        JUMP_IMM  = 2'b01,
        JUMP_REG  = 2'b10
    } jump_e;

    // 2-bit saturating predictor counter; MSB is the taken prediction
    typedef enum logic [1:0] {
        CNT_STRONG_NT = 2'b00,
        CNT_WEAK_NT   = 2'b01,
        CNT_WEAK_T    = 2'b10,
        CNT_STRONG_T  = 2'b11
    } bht_cnt_e;

    // Saturating step of a predictor counter toward the resolved outcome
    function automatic bht_cnt_e bht_next(input bht_cnt_e cur, input logic taken);
        bht_cnt_e nxt;
        nxt = cur;
        case (cur)
            CNT_STRONG_NT: nxt = taken ? CNT_WEAK_NT  : CNT_STRONG_NT;
            CNT_WEAK_NT:   nxt = taken ? CNT_WEAK_T   : CNT_STRONG_NT;
            CNT_WEAK_T:    nxt = taken ? CNT_STRONG_T : CNT_WEAK_NT;
            CNT_STRONG_T:  nxt = taken ? CNT_STRONG_T : CNT_WEAK_T;
            default:       nxt = CNT_WEAK_NT;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/id_branch_predict_bht.sv
// Branch history table: 2^IDX_W two-bit saturating counters with an
// asynchronous read port and a single clocked update port. The read returns
// the value held before any same-edge update.
module id_bht
    import id_branch_predict_pkg::*;
#(
    parameter int IDX_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [IDX_W-1:0] rd_idx,
    output bht_cnt_e         rd_cnt,
    input  logic             upd_en,
    input  logic [IDX_W-1:0] upd_idx,
    input  logic             upd_taken
);

    localparam int unsigned ENTRIES = 1 << IDX_W;

    bht_cnt_e cnt_q [ENTRIES];

    // Combinational read of the current (pre-update) counter
    always_comb begin
        rd_cnt = cnt_q[rd_idx];
    end

    // Whole-table reset to weakly not-taken, otherwise saturating update
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < ENTRIES; i++) begin
                cnt_q[i] <= CNT_WEAK_NT;
            end
        end else if (upd_en) begin
            cnt_q[upd_idx] <= bht_next(cnt_q[upd_idx], upd_taken);
        end
    end

endmodule

// File: rtl/id_branch_predict.sv
// ID-stage branch/jump decode, resolution and BHT-based prediction check.
// All results are registered one cycle after an accepted instruction; a
// saturating counter tracks mispredicted conditional branches.
module id_branch_predict
    import id_branch_predict_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int IDX_W  = 6,
    parameter int CNT_W  = 16
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_valid,
    input  logic              i_stall,
    input  logic [5:0]        i_con_instru,
    input  logic [5:0]        i_con_func,
    input  logic              i_con_rt,
    input  logic [DATA_W-1:0] i_pc,
    input  logic [DATA_W-1:0] i_rs_data,
    input  logic [DATA_W-1:0] i_rt_data,
    input  logic [15:0]       i_imm,
    input  logic [25:0]       i_jtarget,
    output logic              o_valid,
    output logic [2:0]        o_con_bop,
    output logic [1:0]        o_con_jump,
    output logic              o_taken,
    output logic [DATA_W-1:0] o_target,
    output logic              o_pred_taken,
    output logic              o_mispredict,
    output logic [CNT_W-1:0]  o_mp_count
);

    bop_e              bop_d;
    jump_e             jump_d;
    logic              is_cond;
    logic              cond_true;
    logic              taken_d;
    logic [DATA_W-1:0] target_d;
    logic              pred_d;
    logic              misp_d;
    logic              accept;
    logic [DATA_W-1:0] pc_plus4;
    logic [DATA_W-1:0] br_target;
    logic [DATA_W-1:0] j_target;
    logic signed [DATA_W-1:0] rs_s;
    bht_cnt_e          bht_cnt;
    logic [IDX_W-1:0]  bht_idx;

    // Opcode/function decode into branch-op and jump-kind encodings
    always_comb begin
        bop_d  = BOP_NONE;
        jump_d = JUMP_NONE;
        case (i_con_instru)
            OP_BEQ:    bop_d = BOP_BEQ;
            OP_BNE:    bop_d = BOP_BNE;
            OP_BLEZ:   bop_d = BOP_BLEZ;
            OP_BGTZ:   bop_d = BOP_BGTZ;
            OP_REGIMM: bop_d = i_con_rt ? BOP_BGEZ : BOP_BLTZ;
            OP_J,
            OP_JAL:    jump_d = JUMP_IMM;
            OP_SPECIAL: begin
                if (i_con_func == FN_JR || i_con_func == FN_JALR) begin
                    jump_d = JUMP_REG;
                end
            end
            default: begin
                bop_d  = BOP_NONE;
                jump_d = JUMP_NONE;
            end
        endcase
    end

    // Signed condition evaluation and candidate redirect addresses
    always_comb begin
        rs_s      = i_rs_data;
        pc_plus4  = i_pc + DATA_W'(4);
        br_target = pc_plus4 + {{(DATA_W-18){i_imm[15]}}, i_imm, 2'b00};
        j_target  = {pc_plus4[DATA_W-1:28], i_jtarget, 2'b00};
        cond_true = 1'b0;
        case (bop_d)
            BOP_BEQ:  cond_true = (i_rs_data == i_rt_data);
            BOP_BNE:  cond_true = (i_rs_data != i_rt_data);
            BOP_BLEZ: cond_true = (rs_s <= 0);
            BOP_BGTZ: cond_true = (rs_s > 0);
            BOP_BLTZ: cond_true = (rs_s < 0);
            BOP_BGEZ: cond_true = (rs_s >= 0);
            default:  cond_true = 1'b0;
        endcase
    end

    // Resolved outcome, prediction and mispredict flag for this instruction
    always_comb begin
        is_cond  = (bop_d != BOP_NONE);
        taken_d  = 1'b0;
        target_d = '0;
        pred_d   = 1'b0;
        if (is_cond) begin
            taken_d  = cond_true;
            target_d = br_target;
            pred_d   = bht_cnt[1];
        end else if (jump_d == JUMP_IMM) begin
            taken_d  = 1'b1;
            target_d = j_target;
        end else if (jump_d == JUMP_REG) begin
            taken_d  = 1'b1;
            target_d = i_rs_data;
        end
        misp_d = is_cond && (pred_d != taken_d);
        accept = i_valid && !i_stall;
    end

    assign bht_idx = i_pc[IDX_W+1:2];

    id_bht #(
        .IDX_W(IDX_W)
    ) u_bht (
        .clk      (i_clk),
        .rst      (i_rst),
        .rd_idx   (bht_idx),
        .rd_cnt   (bht_cnt),
        .upd_en   (accept && is_cond && !i_rst),
        .upd_idx  (bht_idx),
        .upd_taken(taken_d)
    );

    // Output register: reset wins, stall holds, idle cycles clear results
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_valid      <= 1'b0;
            o_con_bop    <= '0;
            o_con_jump   <= '0;
            o_taken      <= 1'b0;
            o_target     <= '0;
            o_pred_taken <= 1'b0;
            o_mispredict <= 1'b0;
            o_mp_count   <= '0;
        end else if (!i_stall) begin
            if (i_valid) begin
                o_valid      <= 1'b1;
                o_con_bop    <= bop_d;
                o_con_jump   <= jump_d;
                o_taken      <= taken_d;
                o_target     <= target_d;
                o_pred_taken <= pred_d;
                o_mispredict <= misp_d;
                if (misp_d && (o_mp_count != '1)) begin
                    o_mp_count <= o_mp_count + CNT_W'(1);
                end
            end else begin
                o_valid      <= 1'b0;
                o_con_bop    <= '0;
                o_con_jump   <= '0;
                o_taken      <= 1'b0;
                o_target     <= '0;
                o_pred_taken <= 1'b0;
                o_mispredict <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_id_branch_predict.sv
// Scoreboard bench for id_branch_predict: a behavioural model pushes expected
// results for accepted instructions; a monitor pops and compares them.
module tb_id_branch_predict;

    logic        clk = 1'b0;
    logic        rst, valid, stall, con_rt;
    logic [5:0]  instru, func;
    logic [31:0] pc, rs, rt;
    logic [15:0] imm;
    logic [25:0] jt;

    logic        o_valid, o_taken, o_pred_taken, o_mispredict;
    logic [2:0]  o_con_bop;
    logic [1:0]  o_con_jump;
    logic [31:0] o_target;
    logic [15:0] o_mp_count;

    typedef struct {
        logic        valid;
        logic [2:0]  bop;
        logic [1:0]  jump;
        logic        taken;
        logic [31:0] target;
        logic        pred;
        logic        misp;
        logic [15:0] mpc;
    } exp_t;

    exp_t q[$];
    exp_t last;
    int   bht[64];
    int   mpc;
    int   checks = 0;
    int   failures = 0;
    logic acc_prev = 1'b0;

    always #5 clk = ~clk;

    id_branch_predict #(.DATA_W(32), .IDX_W(6), .CNT_W(16)) dut (
        .i_clk(clk), .i_rst(rst), .i_valid(valid), .i_stall(stall),
        .i_con_instru(instru), .i_con_func(func), .i_con_rt(con_rt),
        .i_pc(pc), .i_rs_data(rs), .i_rt_data(rt), .i_imm(imm), .i_jtarget(jt),
        .o_valid(o_valid), .o_con_bop(o_con_bop), .o_con_jump(o_con_jump),
        .o_taken(o_taken), .o_target(o_target), .o_pred_taken(o_pred_taken),
        .o_mispredict(o_mispredict), .o_mp_count(o_mp_count)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic cmp_all(input string tag, input exp_t e);
        chk({tag, "_valid"},  32'(o_valid),      32'(e.valid));
        chk({tag, "_bop"},    32'(o_con_bop),    32'(e.bop));
        chk({tag, "_jump"},   32'(o_con_jump),   32'(e.jump));
        chk({tag, "_taken"},  32'(o_taken),      32'(e.taken));
        chk({tag, "_target"}, o_target,          e.target);
        chk({tag, "_pred"},   32'(o_pred_taken), 32'(e.pred));
        chk({tag, "_misp"},   32'(o_mispredict), 32'(e.misp));
        chk({tag, "_mpc"},    32'(o_mp_count),   32'(e.mpc));
    endtask

    // Reference model of one accepted instruction
    task automatic model_accept();
        exp_t e;
        logic signed [31:0] srs;
        logic [31:0] p4;
        logic cond;
        bit is_br;
        int idx;
        e = '{default: '0};
        e.valid = 1'b1;
        p4 = pc + 32'd4;
        srs = rs;
        cond = 1'b0;
        is_br = 1'b1;
        case (instru)
            6'd4: begin e.bop = 3'd1; cond = (rs == rt); end
            6'd5: begin e.bop = 3'd2; cond = (rs != rt); end
            6'd6: begin e.bop = 3'd3; cond = (srs <= 0); end
            6'd7: begin e.bop = 3'd4; cond = (srs > 0); end
            6'd1: begin
                if (con_rt) begin e.bop = 3'd6; cond = (srs >= 0); end
                else        begin e.bop = 3'd5; cond = (srs < 0);  end
            end
            default: is_br = 1'b0;
        endcase
        if (is_br) begin
            idx = int'((pc / 4) % 64);
            e.pred = (bht[idx] >= 2);
            e.taken = cond;
            e.target = p4 + 32'($signed(imm) * 4);
            e.misp = (e.pred != e.taken);
            if (cond) bht[idx] = (bht[idx] == 3) ? 3 : bht[idx] + 1;
            else      bht[idx] = (bht[idx] == 0) ? 0 : bht[idx] - 1;
            if (e.misp && mpc < 65535) mpc++;
        end else if (instru == 6'd2 || instru == 6'd3) begin
            e.jump = 2'd1;
            e.taken = 1'b1;
            e.target = {p4[31:28], jt, 2'b00};
        end else if (instru == 6'd0 && (func == 6'd8 || func == 6'd9)) begin
            e.jump = 2'd2;
            e.taken = 1'b1;
            e.target = rs;
        end
        e.mpc = 16'(mpc);
        q.push_back(e);
        last = e;
    endtask

    task automatic model_cycle();
        if (rst) begin
            for (int i = 0; i < 64; i++) bht[i] = 1;
            mpc = 0;
            last = '{default: '0};
            q.delete();
        end else if (!stall) begin
            if (valid) model_accept();
            else begin
                last = '{default: '0};
                last.mpc = 16'(mpc);
            end
        end
    endtask

    task automatic cycle(input logic r, input logic v, input logic s);
        rst = r; valid = v; stall = s;
        @(posedge clk);
        model_cycle();
        @(negedge clk);
        if (!(!r && v && !s)) cmp_all("ctl", last);
    endtask

    task automatic set_ins(input logic [5:0] op, input logic [5:0] fn, input logic r,
                           input logic [31:0] p, input logic [31:0] a, input logic [31:0] b,
                           input logic [15:0] im, input logic [25:0] j);
        instru = op; func = fn; con_rt = r; pc = p; rs = a; rt = b; imm = im; jt = j;
    endtask

    function automatic logic [31:0] pick_val();
        case ($urandom_range(0, 5))
            0: return 32'd0;
            1: return 32'd1;
            2: return 32'hFFFF_FFFF;
            3: return 32'd5;
            4: return 32'h8000_0000;
            default: return $urandom();
        endcase
    endfunction

    always @(posedge clk) acc_prev <= valid && !stall && !rst;

    // Monitor: every freshly produced result is matched against the queue
    always @(negedge clk) begin
        exp_t e;
        if (acc_prev) begin
            if (q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL sb_underflow actual=o_valid=%0d expected=no_output", o_valid);
            end else begin
                e = q.pop_front();
                cmp_all("sb", e);
            end
        end
    end

    initial begin
        logic [5:0] ops [8];
        ops = '{6'd4, 6'd5, 6'd6, 6'd7, 6'd1, 6'd2, 6'd3, 6'd0};
        for (int i = 0; i < 64; i++) bht[i] = 1;
        mpc = 0;
        last = '{default: '0};
        set_ins(6'd0, 6'd0, 1'b0, 32'd0, 32'd0, 32'd0, 16'd0, 26'd0);

        cycle(1'b1, 1'b0, 1'b0);
        cycle(1'b1, 1'b1, 1'b1);

        // beq training at pc 0x100: predictions 0,1,1
        set_ins(6'd4, 6'd0, 1'b0, 32'h100, 32'd5, 32'd5, 16'd4, 26'd0);
        cycle(1'b0, 1'b1, 1'b0);
        chk("beq1_target", o_target, 32'h114);
        chk("beq1_pred", 32'(o_pred_taken), 32'd0);
        chk("beq1_misp", 32'(o_mispredict), 32'd1);
        chk("beq1_mpc", 32'(o_mp_count), 32'd1);
        cycle(1'b0, 1'b1, 1'b0);
        chk("beq2_pred", 32'(o_pred_taken), 32'd1);
        cycle(1'b0, 1'b1, 1'b0);
        chk("beq3_pred", 32'(o_pred_taken), 32'd1);
        chk("beq3_mpc", 32'(o_mp_count), 32'd1);
        cycle(1'b0, 1'b1, 1'b0);
        chk("beq4_sat_pred", 32'(o_pred_taken), 32'd1);

        // jr
        set_ins(6'd0, 6'd8, 1'b0, 32'h200, 32'h4000, 32'd0, 16'd0, 26'd0);
        cycle(1'b0, 1'b1, 1'b0);
        chk("jr_jump", 32'(o_con_jump), 32'd2);
        chk("jr_target", o_target, 32'h4000);
        chk("jr_misp", 32'(o_mispredict), 32'd0);

        // bltz / bgez
        set_ins(6'd1, 6'd0, 1'b0, 32'h300, 32'h8000_0000, 32'd0, 16'hFFFF, 26'd0);
        cycle(1'b0, 1'b1, 1'b0);
        chk("bltz_bop", 32'(o_con_bop), 32'd5);
        chk("bltz_taken", 32'(o_taken), 32'd1);
        set_ins(6'd1, 6'd0, 1'b1, 32'h304, 32'd0, 32'd0, 16'd2, 26'd0);
        cycle(1'b0, 1'b1, 1'b0);
        chk("bgez_bop", 32'(o_con_bop), 32'd6);
        chk("bgez_taken", 32'(o_taken), 32'd1);

        // stall: a not-taken branch held at 0x200 must not train the table
        set_ins(6'd4, 6'd0, 1'b0, 32'h200, 32'd1, 32'd1, 16'd8, 26'd0);
        cycle(1'b0, 1'b1, 1'b0);
        set_ins(6'd4, 6'd0, 1'b0, 32'h200, 32'd1, 32'd2, 16'd8, 26'd0);
        repeat (3) cycle(1'b0, 1'b1, 1'b1);
        set_ins(6'd4, 6'd0, 1'b0, 32'h200, 32'd1, 32'd2, 16'd8, 26'd0);
        cycle(1'b0, 1'b1, 1'b0);
        chk("post_stall_pred", 32'(o_pred_taken), 32'd1);

        // reset mid-stream clears training
        set_ins(6'd4, 6'd0, 1'b0, 32'h340, 32'd7, 32'd7, 16'd1, 26'd0);
        cycle(1'b0, 1'b1, 1'b0);
        cycle(1'b0, 1'b1, 1'b0);
        cycle(1'b1, 1'b1, 1'b0);
        cycle(1'b0, 1'b1, 1'b0);
        chk("post_rst_pred", 32'(o_pred_taken), 32'd0);
        cycle(1'b0, 1'b0, 1'b0);

        // randomized stream
        for (int n = 0; n < 600; n++) begin
            logic [5:0] op;
            logic [31:0] p;
            op = ($urandom_range(0, 9) == 0) ? 6'($urandom()) : ops[$urandom_range(0, 7)];
            p = ($urandom_range(0, 3) == 0) ? ($urandom() & 32'hFFFF_FF00) : 32'h1000;
            p = p | (32'($urandom_range(0, 15)) << 2);
            set_ins(op, ($urandom_range(0, 2) == 0) ? 6'($urandom()) : 6'(8 + $urandom_range(0, 1)),
                    1'($urandom()), p, pick_val(), pick_val(), 16'($urandom()), 26'($urandom()));
            cycle(($urandom_range(0, 99) == 0), ($urandom_range(0, 9) != 0),
                  ($urandom_range(0, 9) == 0));
        end

        cycle(1'b0, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 1'b0);
        chk("sb_drained", 32'(q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
